// File: rtl/bhg_pattern_region_writer.sv
// bhg_pattern_region_writer: fills a clipped rectangle of a DDR3 bitmap with a
// solid, LFSR snow, gradient or colour-bar pattern, one pixel write per free cycle.
module bhg_pattern_region_writer #(
   parameter int          PORT_ADDR_SIZE = 25,
   parameter int          PIXEL_WIDTH    = 32,
   parameter logic [31:0] LFSR_SEED      = 32'hACE1_2021,
   parameter int          BAR_SHIFT      = 8
) (
   input  logic                        CLK,
   input  logic                        reset,
   input  logic [2:0]                  DISP_pixel_bytes,
   input  logic [31:0]                 DISP_mem_addr,
   input  logic signed [15:0]          DISP_bitmap_width,
   input  logic signed [15:0]          DISP_bitmap_height,
   input  logic                        start,
   input  logic                        abort,
   input  logic [1:0]                  mode,
   input  logic [31:0]                 fill_color,
   input  logic signed [15:0]          rect_x0,
   input  logic signed [15:0]          rect_y0,
   input  logic signed [15:0]          rect_x1,
   input  logic signed [15:0]          rect_y1,
   output logic                        busy,
   output logic                        done,
   input  logic                        write_busy_in,
   output logic                        write_req_out,
   output logic [PORT_ADDR_SIZE-1:0]   write_adr_out,
   output logic [PIXEL_WIDTH-1:0]      write_data_out,
   output logic [PIXEL_WIDTH/8-1:0]    write_mask_out
);
   localparam int NL = PIXEL_WIDTH / 8;
   localparam int LB = $clog2(NL);

   typedef enum logic [1:0] {S_IDLE, S_SETUP, S_RUN, S_DONE} state_t;
   state_t r_state, w_next;

   logic [1:0]                r_pbs, r_mode, w_pbs;
   logic [31:0]               r_base, r_color, r_stride, r_row, r_lfsr;
   logic signed [15:0]        r_w, r_h, r_x0, r_x1, r_y1, r_x, r_y;
   logic                      r_end, r_req;
   logic [PORT_ADDR_SIZE-1:0] r_adr;
   logic [PIXEL_WIDTH-1:0]    r_data;
   logic [NL-1:0]             r_mask;

   logic signed [15:0]        w_wm1, w_hm1, w_x0c, w_y0c, w_x1c, w_y1c;
   logic                      w_empty, w_issue;
   logic [31:0]               w_stride, w_row0, w_lfsr_nx, w_pix, w_word;
   logic [PORT_ADDR_SIZE-1:0] w_addr;
   logic [2:0]                w_bar;
   logic [3:0]                w_bmask;

   // Row offset built from shifted partial sums rather than a multiplier
   function automatic logic [31:0] f_mul(input logic [15:0] a, input logic [31:0] b);
      logic [31:0] s;
      s = 32'h0;
      for (int i = 0; i < 16; i++) s = s + (a[i] ? (b << i) : 32'h0);
      return s;
   endfunction

   assign w_pbs     = (DISP_pixel_bytes == 3'd1) ? 2'd0 : (DISP_pixel_bytes == 3'd2) ? 2'd1 : 2'd2;
   assign w_wm1     = r_w - 16'sd1;
   assign w_hm1     = r_h - 16'sd1;
   assign w_x0c     = (r_x0 < 16'sd0) ? 16'sd0 : r_x0;
   assign w_y0c     = (r_y < 16'sd0) ? 16'sd0 : r_y;
   assign w_x1c     = (r_x1 > w_wm1) ? w_wm1 : r_x1;
   assign w_y1c     = (r_y1 > w_hm1) ? w_hm1 : r_y1;
   assign w_empty   = (r_w <= 16'sd0) | (r_h <= 16'sd0) | (w_x0c > w_x1c) | (w_y0c > w_y1c);
   assign w_stride  = {16'h0, r_w} << r_pbs;
   assign w_row0    = r_base + f_mul(w_y0c, w_stride);
   assign w_addr    = PORT_ADDR_SIZE'(r_row + ({16'h0, r_x} << r_pbs));
   assign w_lfsr_nx = {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? 32'h8020_0003 : 32'h0);
   assign w_bar     = r_x[BAR_SHIFT+2:BAR_SHIFT];
   assign w_pix     = (r_mode == 2'd0) ? r_color :
                      (r_mode == 2'd1) ? w_lfsr_nx :
                      (r_mode == 2'd2) ? {4{r_x[7:0]}} :
                      {8'h00, {8{w_bar[2]}}, {8{w_bar[1]}}, {8{w_bar[0]}}};
   assign w_word    = (r_pbs == 2'd0) ? {4{w_pix[7:0]}} : (r_pbs == 2'd1) ? {2{w_pix[15:0]}} : w_pix;
   assign w_bmask   = (r_pbs == 2'd0) ? 4'h1 : (r_pbs == 2'd1) ? 4'h3 : 4'hF;
   assign w_issue   = (r_state == S_RUN) & ~write_busy_in & ~abort & ~r_end;

   always_ff @(posedge CLK or negedge reset)
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_next;

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  w_next = start ? S_SETUP : S_IDLE;
         S_SETUP: w_next = (abort | w_empty) ? S_DONE : S_RUN;
         S_RUN:   w_next = (abort | r_end) ? S_DONE : S_RUN;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      busy = r_state != S_IDLE;
      done = r_state == S_DONE;
   end

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         r_pbs    <= '0;
         r_mode   <= '0;
         r_base   <= '0;
         r_color  <= '0;
         r_stride <= '0;
         r_row    <= '0;
         r_lfsr   <= LFSR_SEED;
         r_w      <= '0;
         r_h      <= '0;
         r_x0     <= '0;
         r_x1     <= '0;
         r_y1     <= '0;
         r_x      <= '0;
         r_y      <= '0;
         r_end    <= 1'b0;
         r_req    <= 1'b0;
         r_adr    <= '0;
         r_data   <= '0;
         r_mask   <= '0;
      end else begin
         r_req <= w_issue;
         // r_y carries the raw y0 until SETUP replaces it with the clamped row
         if (r_state == S_IDLE && start) begin
            r_pbs   <= w_pbs;
            r_mode  <= mode;
            r_base  <= DISP_mem_addr;
            r_color <= fill_color;
            r_w     <= DISP_bitmap_width;
            r_h     <= DISP_bitmap_height;
            r_x0    <= rect_x0;
            r_x1    <= rect_x1;
            r_y1    <= rect_y1;
            r_y     <= rect_y0;
            r_end   <= 1'b0;
         end
         if (r_state == S_SETUP) begin
            r_x0     <= w_x0c;
            r_x1     <= w_x1c;
            r_y1     <= w_y1c;
            r_x      <= w_x0c;
            r_y      <= w_y0c;
            r_stride <= w_stride;
            r_row    <= w_row0;
         end
         if (w_issue) begin
            r_adr  <= w_addr;
            r_data <= {(PIXEL_WIDTH/32){w_word}};
            r_mask <= NL'(w_bmask) << w_addr[LB-1:0];
            if (r_mode == 2'd1) r_lfsr <= w_lfsr_nx;
            if (r_x == r_x1) begin
               r_x   <= r_x0;
               r_y   <= r_y + 16'sd1;
               r_row <= r_row + r_stride;
               r_end <= r_y == r_y1;
            end else begin
               r_x <= r_x + 16'sd1;
            end
         end
      end
   end

   assign write_req_out  = r_req;
   assign write_adr_out  = r_adr;
   assign write_data_out = r_data;
   assign write_mask_out = r_mask;
endmodule

// File: doc/bhg_pattern_region_writer.md
Name: bhg_pattern_region_writer

Overview:
- Parametrised successor to the current test-pattern drawing engine.
- Fills a clipped rectangular region of a bitmap in DDR3 with one of four patterns: solid, LFSR snow, gradient or colour bars.
- Supports 8/16/32-bit pixels, one pixel-write request per accepted cycle.
- Sits between the control/button logic and a BrianHG DDR3 write port.

Parameters:
- PORT_ADDR_SIZE, 25: byte-address width of the write port.
- PIXEL_WIDTH, 32: write data width in bits (multiple of 32).
- LFSR_SEED, 32'hACE1_2021: snow LFSR reset value (must be non-zero).
- BAR_SHIFT, 8: colour-bar index is x[BAR_SHIFT+2:BAR_SHIFT].

Ports:
- CLK  in  1  sole clock.
- reset  in  1  asynchronous, active-low (0 = reset).
- DISP_pixel_bytes  in  3  1, 2 or 4; other values are treated as 4.
- DISP_mem_addr  in  32  byte address of pixel (0,0).
- DISP_bitmap_width  in  16 signed  pixels per row.
- DISP_bitmap_height  in  16 signed  rows.
- start  in  1  one-cycle request; ignored unless idle.
- abort  in  1  stops an active fill.
- mode  in  2  0 solid, 1 snow, 2 gradient, 3 bars.
- fill_color  in  32  colour for mode 0.
- rect_x0, rect_y0, rect_x1, rect_y1  in  16 signed each  inclusive region corners.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse at completion or abort.
- write_busy_in  in  1  write port cannot accept.
- write_req_out  out  1  one-cycle write strobe per pixel.
- write_adr_out  out  PORT_ADDR_SIZE  byte address.
- write_data_out  out  PIXEL_WIDTH  pixel data.
- write_mask_out  out  PIXEL_WIDTH/8  byte enables.

Behaviour:
- Reset: all outputs 0; FSM = IDLE; LFSR = LFSR_SEED. Asserting reset mid-fill abandons the fill immediately with no done pulse.
- IDLE: start=1 latches all DISP_*, mode, fill_color and rect_* inputs, sets busy=1 and goes to SETUP. Input changes after acceptance have no effect.
- SETUP (1 cycle):
  - Clamp x0,y0 to >=0, x1 to <=width-1 and y1 to <=height-1.
  - If x0>x1 or y0>y1, or width<=0 or height<=0, go to DONE with zero writes.
  - Otherwise stride = width*pb (pb = pixel bytes) and row_base = DISP_mem_addr + y0*stride. Use shift/add, not a general multiplier.
  - Go to RUN.
- RUN:
  - At each rising edge where write_busy_in=0, the next cycle drives write_req_out=1 with the current pixel's address, data and mask, then advances x.
  - If write_busy_in=1, write_req_out=0 and addr/data/mask hold. Sustained throughput is 1 pixel/clock.
  - At x==x1: x=x0, y+1, row_base+=stride. After the pixel at (x1,y1) is issued, go to DONE.
- Address: write_adr_out = (row_base + x*pb) truncated to PORT_ADDR_SIZE. Wrap-around past 2^PORT_ADDR_SIZE is silent.
- Data/mask:
  - The pixel value (low pb*8 bits) is replicated across all PIXEL_WIDTH/8 lanes.
  - The mask enables the pb bytes starting at lane (address mod PIXEL_WIDTH/8); address is pb-aligned by construction.
- Patterns:
  - mode 0: fill_color.
  - mode 1: Galois LFSR, taps 32,22,2,1. Advances only on each issued pixel in mode 1; not reseeded by start.
  - mode 2: {4{x[7:0]}}.
  - mode 3: b = x[BAR_SHIFT+2:BAR_SHIFT]; pixel = {8'h00, b[2]?FF:00, b[1]?FF:00, b[0]?FF:00}.
- abort in SETUP/RUN: no write_req_out after the abort edge; go to DONE. abort in IDLE is ignored.
- DONE: done=1 for one cycle, busy=0 on the next cycle, return to IDLE.
- Simultaneous start+abort in IDLE: start wins.
- start during busy: ignored, no queueing.

Test Plan:
- pb=4, addr=0, width=2048, rect (0,0)-(3,1), mode 0, fill_color=32'h11223344, write_busy_in=0:
  - Required: 8 consecutive req pulses at addresses 0,4,8,12,8192,8196,8200,8204.
  - Data 11223344 with mask 4'hF on every write.
  - done pulses 1 cycle after the last req.
- Same rect with write_busy_in high for 3 cycles mid-row:
  - Required: req low for those cycles with address held, no pixel lost or duplicated, 8 writes total.
- pb=1, rect (5,0)-(7,0), mode 2:
  - Required: addresses 5,6,7; masks 4'b0010, 4'b0100, 4'b1000; data 32'h05050505, 06060606, 07070707.
- rect (-4,-4)-(5000,5000) with width=16, height=2:
  - Required: exactly 32 writes covering (0,0)-(15,1).
- rect x0=10, x1=3:
  - Required: zero writes; done pulses 2 cycles after start.
- abort asserted after the 3rd write of a 100-pixel fill:
  - Required: no 4th req, done pulse, busy falls.
- Mode 1 with default seed after reset:
  - Required: first pixel = LFSR_SEED advanced once; a second start continues the sequence without reseeding.
